// File: rtl/wb_burst_fetch.sv
// Wishbone burst-read master that streams a linear PSRAM region into a local FIFO.
//
// A consumer supplies start/base_addr/word_count. The block fetches the region as a series of
// incrementing linear bursts (cti=010, last beat cti=111, bte=00). No burst crosses a
// 2^BURST_BITS-word boundary. A burst is launched only once the FIFO has room for the whole
// chunk, so the FIFO can never overflow. Words leave through a first-word-fall-through
// valid/ready port.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   start, base_addr,         fetch request; sampled only while busy is low
//   word_count
//   busy, done, error         status: busy is high while fetching, done is a one-cycle pulse
//                             on completion, error is sticky and cleared by the next start
//   data_o, valid_o, ready_i  FIFO read side (first-word fall-through)
//   wbm_*                     wishbone read master; every output is registered
//
// COUNT_BITS must exceed BURST_BITS, and FIFO_BITS must be >= BURST_BITS.
module wb_burst_fetch #(
  parameter int unsigned BURST_BITS = 3,
  parameter int unsigned FIFO_BITS  = 4,
  parameter int unsigned COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:2]           base_addr,
  input  logic [COUNT_BITS-1:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic [31:2]           wbm_addr_o,
  output logic [2:0]            wbm_cti_o,
  output logic [1:0]            wbm_bte_o,
  output logic [3:0]            wbm_sel_o,
  output logic                  wbm_we_o,
  input  logic [31:0]           wbm_data_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i
);

  localparam int unsigned Depth = 1 << FIFO_BITS;
  localparam logic [BURST_BITS:0] BurstLenW = {1'b1, {BURST_BITS{1'b0}}};
  localparam logic [FIFO_BITS:0]  DepthW    = {1'b1, {FIFO_BITS{1'b0}}};

  localparam logic [2:0] CtiNone = 3'b000;
  localparam logic [2:0] CtiIncr = 3'b010;
  localparam logic [2:0] CtiEnd  = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSpace,
    StBurst
  } state_e;

  state_e                state_q, state_d;
  logic [31:2]           addr_q, addr_d;
  logic [COUNT_BITS-1:0] rem_q, rem_d;
  logic [BURST_BITS:0]   beats_q, beats_d;
  logic                  cyc_q, cyc_d;
  logic [2:0]            cti_q, cti_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  // FIFO storage and pointers
  logic [31:0]          mem_q [Depth];
  logic [FIFO_BITS-1:0] wptr_q, rptr_q;
  logic [FIFO_BITS:0]   fifo_cnt_q;
  logic                 push, pop, flush;

  // Chunk sizing
  logic [BURST_BITS:0]   room;
  logic [COUNT_BITS-1:0] room_ext;
  logic [BURST_BITS:0]   len;
  logic [FIFO_BITS:0]    free_slots;

  // Words left before the next 2^BURST_BITS boundary; this shortens the first chunk so that
  // every later burst is aligned.
  always_comb begin
    room       = BurstLenW - {1'b0, addr_q[BURST_BITS+1:2]};
    room_ext   = COUNT_BITS'(room);
    len        = (rem_q < room_ext) ? rem_q[BURST_BITS:0] : room;
    // A pop in this cycle is not counted as freeing a slot.
    free_slots = DepthW - fifo_cnt_q;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    cyc_d   = cyc_q;
    cti_d   = cti_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    flush   = 1'b0;
    push    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = word_count;
          error_d = 1'b0;
          flush   = 1'b1;
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = StWaitSpace;
          end
        end
      end

      StWaitSpace: begin
        if (free_slots >= (FIFO_BITS+1)'(len)) begin
          cyc_d   = 1'b1;
          beats_d = len;
          cti_d   = (len == (BURST_BITS+1)'(1)) ? CtiEnd : CtiIncr;
          state_d = StBurst;
        end
      end

      StBurst: begin
        // err takes priority over ack; the word on an err beat is discarded.
        if (wbm_err_i) begin
          cyc_d   = 1'b0;
          cti_d   = CtiNone;
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (wbm_ack_i) begin
          push    = 1'b1;
          addr_d  = addr_q + 30'd1;
          rem_d   = rem_q - COUNT_BITS'(1);
          beats_d = beats_q - (BURST_BITS+1)'(1);
          // The next beat is the final one when two beats remain before this ack.
          cti_d   = (beats_q == (BURST_BITS+1)'(2)) ? CtiEnd : CtiIncr;
          if (beats_q == (BURST_BITS+1)'(1)) begin
            cyc_d = 1'b0;
            cti_d = CtiNone;
            if (rem_q == COUNT_BITS'(1)) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = StIdle;
            end else begin
              // Passing through StWaitSpace guarantees an idle bus cycle for arbitration.
              state_d = StWaitSpace;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= CtiNone;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      cyc_q   <= cyc_d;
      cti_q   <= cti_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // FIFO
  assign valid_o = (fifo_cnt_q != '0);
  assign pop     = valid_o & ready_i;
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + FIFO_BITS'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + FIFO_BITS'(1);
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + (FIFO_BITS+1)'(1);
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - (FIFO_BITS+1)'(1);
      end
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wbm_data_i;
    end
  end

  // Outputs
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_addr_o = addr_q;
  assign wbm_cti_o  = cti_q;
  assign wbm_bte_o  = 2'b00;
  assign wbm_sel_o  = 4'b1111;
  assign wbm_we_o   = 1'b0;

endmodule

// File: tb/tb_wb_burst_fetch.sv
module tb_wb_burst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [29:0] base_addr;
  logic [15:0] word_count;
  logic        busy, done, error;
  logic [31:0] data_o;
  logic        valid_o, ready_i;
  logic        wbm_cyc_o, wbm_stb_o;
  logic [29:0] wbm_addr_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic [31:0] wbm_data_i;
  logic        wbm_ack_i, wbm_err_i;

  always #5 clk = ~clk;

  wb_burst_fetch #(
    .BURST_BITS(3),
    .FIFO_BITS (4),
    .COUNT_BITS(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_addr_o(wbm_addr_o),
    .wbm_cti_o (wbm_cti_o),
    .wbm_bte_o (wbm_bte_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_data_i(wbm_data_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Slave memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b11} ^ 32'hC3A5_0F00;
  endfunction

  // Slave: acks every strobed cycle; raises err (together with ack) on beat number err_at.
  int   beat_total = 0;
  int   err_at     = -1;
  logic stray_ack;
  logic err_now;
  assign err_now    = wbm_cyc_o && wbm_stb_o && (beat_total == err_at);
  assign wbm_err_i  = err_now;
  assign wbm_ack_i  = (wbm_cyc_o && wbm_stb_o) || stray_ack;
  assign wbm_data_i = mem_word(wbm_addr_o);

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && !wbm_err_i) beat_total <= beat_total + 1;
  end

  // Scoreboards: expected FIFO words and expected bus beats {addr, cti}.
  logic [31:0] exp_data[$];
  logic [32:0] exp_beat[$];
  int          cyc_rises = 0;
  int          done_cnt  = 0;
  logic        cyc_prev  = 1'b0;

  always @(negedge clk) begin
    logic [31:0] ed;
    logic [32:0] eb;
    if (!rst) begin
      if (valid_o && ready_i) begin
        if (exp_data.size() == 0) begin
          chk("data_unexpected", data_o, 32'hxxxx_xxxx);
        end else begin
          ed = exp_data.pop_front();
          chk("fifo_data", data_o, ed);
        end
      end
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && !wbm_err_i) begin
        if (exp_beat.size() == 0) begin
          chk("beat_unexpected", 32'(wbm_addr_o), 32'hxxxx_xxxx);
        end else begin
          eb = exp_beat.pop_front();
          chk("beat_addr", 32'(wbm_addr_o), 32'(eb[32:3]));
          chk("beat_cti", 32'(wbm_cti_o), 32'(eb[2:0]));
          chk("beat_bte_sel_we", 32'({wbm_bte_o, wbm_sel_o, wbm_we_o}), 32'h1E);
        end
      end
      if (wbm_cyc_o && !cyc_prev) cyc_rises++;
      if (done) done_cnt++;
    end
    cyc_prev = wbm_cyc_o;
  end

  task automatic cyc_wait();
    @(posedge clk);
    #1;
  endtask

  // Expected beats: a burst ends at the last word or at an 8-word boundary.
  task automatic expect_fetch(input logic [29:0] b, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [29:0] a;
      logic        last;
      a    = b + 30'(i);
      last = (i == cnt - 1) || (a[2:0] == 3'b111);
      exp_beat.push_back({a, last ? 3'b111 : 3'b010});
      exp_data.push_back(mem_word(a));
    end
  endtask

  task automatic do_start(input logic [29:0] b, input logic [15:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    cyc_wait();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0, input int limit);
    for (int k = 0; k < limit && done_cnt == d0; k++) cyc_wait();
    chk(name, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic drain(input string name, input int limit);
    for (int k = 0; k < limit && (exp_data.size() + exp_beat.size()) != 0; k++) cyc_wait();
    chk(name, 32'(exp_data.size() + exp_beat.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, b0;
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    ready_i    = 1'b0;
    stray_ack  = 1'b0;
    repeat (3) cyc_wait();
    chk("reset_state", 32'({busy, done, error, valid_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o}), 32'd0);
    chk("reset_addr", 32'(wbm_addr_o), 32'd0);
    rst = 1'b0;
    cyc_wait();

    // 1: aligned 8-word burst
    ready_i = 1'b1;
    expect_fetch(30'h100, 8);
    r0 = cyc_rises; d0 = done_cnt;
    do_start(30'h100, 16'd8);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done", d0, 100);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    drain("t1_drain", 50);
    chk("t1_bursts", 32'(cyc_rises - r0), 32'd1);

    // 2: unaligned start: bursts of 3 then 7
    expect_fetch(30'h105, 10);
    r0 = cyc_rises; d0 = done_cnt;
    do_start(30'h105, 16'd10);
    wait_done("t2_done", d0, 100);
    drain("t2_drain", 50);
    chk("t2_bursts", 32'(cyc_rises - r0), 32'd2);

    // 3: consumer stalled until the FIFO is full
    ready_i = 1'b0;
    expect_fetch(30'h200, 40);
    r0 = cyc_rises; d0 = done_cnt; b0 = beat_total;
    do_start(30'h200, 16'd40);
    for (int k = 0; k < 300 && (beat_total - b0) < 16; k++) cyc_wait();
    repeat (10) cyc_wait();
    chk("t3_stall_beats", 32'(beat_total - b0), 32'd16);
    chk("t3_stall_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("t3_stall_busy", 32'(busy), 32'd1);
    ready_i = 1'b1;
    wait_done("t3_done", d0, 1000);
    drain("t3_drain", 50);
    chk("t3_beats", 32'(beat_total - b0), 32'd40);
    chk("t3_bursts", 32'(cyc_rises - r0), 32'd5);

    // 4: err on the 3rd beat, then a clean refetch
    ready_i = 1'b0;
    exp_beat.push_back({30'h300, 3'b010});
    exp_beat.push_back({30'h301, 3'b010});
    exp_data.push_back(mem_word(30'h300));
    exp_data.push_back(mem_word(30'h301));
    d0 = done_cnt; b0 = beat_total;
    err_at = beat_total + 2;
    do_start(30'h300, 16'd8);
    for (int k = 0; k < 50 && !error; k++) cyc_wait();
    err_at = -1;
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(valid_o), 32'd1);
    chk("t4_cyc", 32'(wbm_cyc_o), 32'd0);
    repeat (3) cyc_wait();
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t4_beats", 32'(beat_total - b0), 32'd2);
    ready_i = 1'b1;
    drain("t4_drain_err", 50);
    chk("t4_empty", 32'(valid_o), 32'd0);
    expect_fetch(30'h300, 8);
    d0 = done_cnt;
    do_start(30'h300, 16'd8);
    chk("t4_error_cleared", 32'(error), 32'd0);
    wait_done("t4_refetch_done", d0, 100);
    drain("t4_drain", 50);

    // 5: reset mid-burst, then a single-beat fetch
    ready_i = 1'b0;
    expect_fetch(30'h400, 8);
    b0 = beat_total;
    do_start(30'h400, 16'd8);
    for (int k = 0; k < 100 && (beat_total - b0) < 3; k++) cyc_wait();
    rst = 1'b1;
    cyc_wait();
    chk("t5_rst_state", 32'({wbm_cyc_o, wbm_stb_o, valid_o, busy}), 32'd0);
    exp_data.delete();
    exp_beat.delete();
    rst = 1'b0;
    cyc_wait();
    chk("t5_no_push", 32'(valid_o), 32'd0);
    ready_i = 1'b1;
    expect_fetch(30'h40B, 1);
    r0 = cyc_rises; d0 = done_cnt;
    do_start(30'h40B, 16'd1);
    wait_done("t5_done", d0, 50);
    drain("t5_drain", 50);
    chk("t5_bursts", 32'(cyc_rises - r0), 32'd1);

    // 6: zero-length fetch, stray ack, and start while busy
    r0 = cyc_rises; d0 = done_cnt;
    do_start(30'h500, 16'd0);
    chk("t6_zero_done", 32'({done, busy}), 32'b10);
    cyc_wait();
    chk("t6_zero_pulse", 32'(done), 32'd0);
    stray_ack = 1'b1;
    cyc_wait();
    stray_ack = 1'b0;
    repeat (3) cyc_wait();
    chk("t6_zero_nobus", 32'(cyc_rises - r0), 32'd0);
    chk("t6_stray_ack", 32'(valid_o), 32'd0);
    chk("t6_zero_count", 32'(done_cnt - d0), 32'd1);
    expect_fetch(30'h500, 8);
    r0 = cyc_rises; d0 = done_cnt; b0 = beat_total;
    do_start(30'h500, 16'd8);
    repeat (2) cyc_wait();
    chk("t6_busy", 32'(busy), 32'd1);
    do_start(30'h600, 16'd3);
    wait_done("t6_done", d0, 100);
    drain("t6_drain", 50);
    repeat (5) cyc_wait();
    chk("t6_beats", 32'(beat_total - b0), 32'd8);
    chk("t6_bursts", 32'(cyc_rises - r0), 32'd1);
    chk("t6_single_done", 32'(done_cnt - d0), 32'd1);
    chk("t6_idle", 32'({busy, wbm_cyc_o}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
